// File: rtl/mc_pkg.sv
// Shared types and encodings for the multicycle RV32I control sequencer.
package mc_pkg;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    FAULT  = 3'd5
  } state_t;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  typedef enum logic [3:0] {
    ALU_ADD    = 4'd0,
    ALU_SUB    = 4'd1,
    ALU_SLL    = 4'd2,
    ALU_SLT    = 4'd3,
    ALU_SLTU   = 4'd4,
    ALU_XOR    = 4'd5,
    ALU_SRL    = 4'd6,
    ALU_SRA    = 4'd7,
    ALU_OR     = 4'd8,
    ALU_AND    = 4'd9,
    ALU_PASS_B = 4'd10
  } alu_op_t;

  typedef enum logic [3:0] {
    CL_OP, CL_OPIMM, CL_LOAD, CL_STORE, CL_BRANCH,
    CL_JAL, CL_JALR, CL_LUI, CL_AUIPC, CL_ILLEGAL
  } iclass_t;

  localparam logic [1:0] PC_SRC_PLUS4 = 2'b00;
  localparam logic [1:0] PC_SRC_ALU   = 2'b01;
  localparam logic [1:0] PC_SRC_TRAP  = 2'b10;

  localparam logic [1:0] RU_SRC_ALU = 2'b00;
  localparam logic [1:0] RU_SRC_MDR = 2'b01;
  localparam logic [1:0] RU_SRC_PC4 = 2'b10;

  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_U = 3'd3;
  localparam logic [2:0] IMM_J = 3'd4;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

  function automatic logic is_mem_class(iclass_t c);
    return (c == CL_LOAD) || (c == CL_STORE);
  endfunction

endpackage

// File: rtl/mc_decoder.sv
// Combinational instruction classifier: class, legality, ALU operation,
// immediate format and ALU operand selects.
import mc_pkg::*;

module mc_decoder (
  input  logic [31:0] instr,
  output iclass_t     iclass,
  output logic        legal,
  output alu_op_t     alu_op,
  output logic [2:0]  imm_src,
  output logic        alu_a_src,
  output logic        alu_b_src
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       alt;
  logic       unused_bits;

  assign opcode      = instr[6:0];
  assign funct3      = instr[14:12];
  assign alt         = instr[30];
  assign unused_bits = ^{instr[31], instr[29:15], instr[11:7]};

  // SUB only exists in register form; SRAI uses the same bit as SRA.
  function automatic alu_op_t arith(logic [2:0] f3, logic f7b5, logic is_reg);
    case (f3)
      3'b000:  return (f7b5 && is_reg) ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return f7b5 ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  always_comb begin
    iclass    = CL_ILLEGAL;
    alu_op    = ALU_ADD;
    imm_src   = IMM_I;
    alu_a_src = 1'b0;
    alu_b_src = 1'b0;
    case (opcode)
      OPC_OP: begin
        iclass = CL_OP;
        alu_op = arith(funct3, alt, 1'b1);
      end
      OPC_OPIMM: begin
        iclass    = CL_OPIMM;
        alu_op    = arith(funct3, alt, 1'b0);
        alu_b_src = 1'b1;
      end
      OPC_LOAD: begin
        iclass    = CL_LOAD;
        alu_b_src = 1'b1;
      end
      OPC_STORE: begin
        iclass    = CL_STORE;
        imm_src   = IMM_S;
        alu_b_src = 1'b1;
      end
      OPC_BRANCH: begin
        iclass    = CL_BRANCH;
        imm_src   = IMM_B;
        alu_a_src = 1'b1;
        alu_b_src = 1'b1;
      end
      OPC_JAL: begin
        iclass    = CL_JAL;
        imm_src   = IMM_J;
        alu_a_src = 1'b1;
        alu_b_src = 1'b1;
      end
      OPC_JALR: begin
        iclass    = CL_JALR;
        alu_b_src = 1'b1;
      end
      OPC_LUI: begin
        iclass    = CL_LUI;
        alu_op    = ALU_PASS_B;
        imm_src   = IMM_U;
        alu_b_src = 1'b1;
      end
      OPC_AUIPC: begin
        iclass    = CL_AUIPC;
        imm_src   = IMM_U;
        alu_a_src = 1'b1;
        alu_b_src = 1'b1;
      end
      default: ;
    endcase
    legal = (iclass != CL_ILLEGAL);
  end

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle control sequencer: shared memory port handshake with timeout,
// fault handling and datapath control decode.
import mc_pkg::*;

module mc_control_fsm #(
  parameter int unsigned MEM_TIMEOUT    = 16,
  parameter bit          TRAP_VECTOR_EN = 1'b1
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic        br_taken,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_addr_src,
  output logic [2:0]  dm_ctrl,
  output logic        ir_we,
  output logic        mdr_we,
  output logic        pc_we,
  output logic [1:0]  pc_src,
  output logic        ru_wr,
  output logic [1:0]  ru_data_src,
  output logic        alu_a_src,
  output logic        alu_b_src,
  output logic [3:0]  alu_op,
  output logic [2:0]  imm_src,
  output logic        instr_retired,
  output logic        fault,
  output logic [1:0]  fault_cause,
  output logic        state_dbg_unused_guard,
  output logic [2:0]  state_dbg
);

  localparam logic [7:0] CNT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t     state, state_next;
  logic [7:0] cnt, cnt_next;
  logic [1:0] cause_next;
  logic       fault_d;
  logic       waiting, timeout;

  iclass_t    iclass;
  logic       legal;
  alu_op_t    dec_alu_op;
  logic [2:0] dec_imm_src;
  logic       dec_a_src, dec_b_src;

  mc_decoder u_decoder (
    .instr     (instr),
    .iclass    (iclass),
    .legal     (legal),
    .alu_op    (dec_alu_op),
    .imm_src   (dec_imm_src),
    .alu_a_src (dec_a_src),
    .alu_b_src (dec_b_src)
  );

  assign dm_ctrl   = instr[14:12];
  assign state_dbg = state;
  assign state_dbg_unused_guard = 1'b0;
  // Pulse only on entry so a parked FAULT state does not keep signalling.
  assign fault     = (state == FAULT) && !fault_d;

  assign waiting = ((state == FETCH) || (state == MEM)) && !mem_ready;
  assign timeout = waiting && (cnt >= CNT_LAST);

  always_comb begin
    state_next    = state;
    cause_next    = fault_cause;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    mem_addr_src  = 1'b0;
    ir_we         = 1'b0;
    mdr_we        = 1'b0;
    pc_we         = 1'b0;
    pc_src        = PC_SRC_PLUS4;
    ru_wr         = 1'b0;
    ru_data_src   = RU_SRC_ALU;
    alu_a_src     = 1'b0;
    alu_b_src     = 1'b0;
    alu_op        = ALU_ADD;
    imm_src       = IMM_I;
    instr_retired = 1'b0;

    if ((state == EXEC) || (state == MEM) || (state == WB)) begin
      alu_a_src = dec_a_src;
      alu_b_src = dec_b_src;
      alu_op    = dec_alu_op;
      imm_src   = dec_imm_src;
    end

    case (state)
      FETCH: begin
        mem_req = 1'b1;
        if (timeout) begin
          state_next = FAULT;
          cause_next = CAUSE_TIMEOUT;
        end else if (mem_ready) begin
          ir_we      = 1'b1;
          state_next = DECODE;
        end
      end
      DECODE: begin
        if (legal) begin
          state_next = EXEC;
        end else begin
          state_next = FAULT;
          cause_next = CAUSE_ILLEGAL;
        end
      end
      EXEC: begin
        if (iclass == CL_BRANCH) begin
          pc_we         = 1'b1;
          pc_src        = br_taken ? PC_SRC_ALU : PC_SRC_PLUS4;
          instr_retired = 1'b1;
          state_next    = FETCH;
        end else if (is_mem_class(iclass)) begin
          state_next = MEM;
        end else begin
          state_next = WB;
        end
      end
      MEM: begin
        mem_req      = 1'b1;
        mem_addr_src = 1'b1;
        mem_we       = (iclass == CL_STORE);
        if (timeout) begin
          state_next = FAULT;
          cause_next = CAUSE_TIMEOUT;
        end else if (mem_ready) begin
          if (iclass == CL_STORE) begin
            pc_we         = 1'b1;
            instr_retired = 1'b1;
            state_next    = FETCH;
          end else begin
            mdr_we     = 1'b1;
            state_next = WB;
          end
        end
      end
      WB: begin
        ru_wr         = 1'b1;
        pc_we         = 1'b1;
        instr_retired = 1'b1;
        state_next    = FETCH;
        if ((iclass == CL_JAL) || (iclass == CL_JALR)) begin
          ru_data_src = RU_SRC_PC4;
          pc_src      = PC_SRC_ALU;
        end else if (iclass == CL_LOAD) begin
          ru_data_src = RU_SRC_MDR;
        end
      end
      FAULT: begin
        if (TRAP_VECTOR_EN) begin
          pc_we      = 1'b1;
          pc_src     = PC_SRC_TRAP;
          state_next = FETCH;
        end
      end
      default: state_next = FETCH;
    endcase

    // Reset abandons any in-flight transaction without side effects.
    if (reset) begin
      mem_req       = 1'b0;
      mem_we        = 1'b0;
      ir_we         = 1'b0;
      mdr_we        = 1'b0;
      pc_we         = 1'b0;
      ru_wr         = 1'b0;
      instr_retired = 1'b0;
    end

    cnt_next = (waiting && (state_next == state)) ? cnt + 8'd1 : '0;
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state       <= FETCH;
      cnt         <= '0;
      fault_cause <= CAUSE_NONE;
      fault_d     <= 1'b0;
    end else begin
      state       <= state_next;
      cnt         <= cnt_next;
      fault_cause <= cause_next;
      fault_d     <= (state == FAULT);
    end
  end

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed table-driven bench for mc_control_fsm (MEM_TIMEOUT=4, trap vector on).
module tb_mc_control_fsm;

  logic        CLK = 1'b0;
  logic        reset, br_taken, mem_ready;
  logic [31:0] instr;
  logic        mem_req, mem_we, mem_addr_src, ir_we, mdr_we, pc_we, ru_wr;
  logic        alu_a_src, alu_b_src, instr_retired, fault, guard;
  logic [2:0]  dm_ctrl, imm_src, state_dbg;
  logic [1:0]  pc_src, ru_data_src, fault_cause;
  logic [3:0]  alu_op;

  always #5 CLK = ~CLK;

  mc_control_fsm #(.MEM_TIMEOUT(4), .TRAP_VECTOR_EN(1'b1)) dut (
    .CLK(CLK), .reset(reset), .instr(instr), .br_taken(br_taken),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr_src(mem_addr_src), .dm_ctrl(dm_ctrl), .ir_we(ir_we),
    .mdr_we(mdr_we), .pc_we(pc_we), .pc_src(pc_src), .ru_wr(ru_wr),
    .ru_data_src(ru_data_src), .alu_a_src(alu_a_src), .alu_b_src(alu_b_src),
    .alu_op(alu_op), .imm_src(imm_src), .instr_retired(instr_retired),
    .fault(fault), .fault_cause(fault_cause),
    .state_dbg_unused_guard(guard), .state_dbg(state_dbg)
  );

  localparam logic [31:0] ADD = 32'h002081B3, SUB = 32'h40208233;
  localparam logic [31:0] LW  = 32'h0000A183, SW  = 32'h0020A023;
  localparam logic [31:0] BEQ = 32'h00208463, JAL = 32'h008000EF;
  localparam logic [31:0] LUI = 32'h123452B7, ILL = 32'h0000007F;

  localparam logic [2:0] F = 3'd0, D = 3'd1, E = 3'd2, M = 3'd3, W = 3'd4, X = 3'd5;
  // strobe order: {mem_req, mem_we, ir_we, mdr_we, pc_we, ru_wr}
  localparam logic [5:0] S0 = 6'b000000, SF = 6'b100000, SFI = 6'b101000;
  localparam logic [5:0] SMW = 6'b110000, SML = 6'b100100, SMS = 6'b110010;
  localparam logic [5:0] SPC = 6'b000010, SWB = 6'b000011;

  typedef struct {
    logic        rst;
    logic [31:0] ins;
    logic        br, rdy;
    logic [2:0]  st;
    logic [5:0]  strb;
    logic [1:0]  pcs, rus;
    logic        addr, ret, flt;
    logic [1:0]  cause;
    logic        chk;
    logic [5:0]  alu;
    logic [2:0]  imm;
  } vec_t;

  vec_t tbl[$];
  int unsigned total = 0, bad = 0;

  function automatic void add(logic rst, logic [31:0] ins, logic br, logic rdy,
                              logic [2:0] st, logic [5:0] strb, logic [1:0] pcs,
                              logic [1:0] rus, logic addr, logic ret, logic flt,
                              logic [1:0] cause);
    vec_t v;
    v = '{rst, ins, br, rdy, st, strb, pcs, rus, addr, ret, flt, cause, 1'b0, 6'd0, 3'd0};
    tbl.push_back(v);
  endfunction

  function automatic void ex(logic [31:0] ins, logic br, logic [5:0] strb, logic [1:0] pcs,
                             logic ret, logic [1:0] cause, logic [5:0] alu, logic [2:0] imm);
    vec_t v;
    v = '{1'b0, ins, br, 1'b1, E, strb, pcs, 2'b00, 1'b0, ret, 1'b0, cause, 1'b1, alu, imm};
    tbl.push_back(v);
  endfunction

  function automatic void fd(logic [31:0] ins, logic [1:0] cause);
    add(0, ins, 0, 1, F, SFI, 2'b00, 2'b00, 0, 0, 0, cause);
    add(0, ins, 0, 1, D, S0,  2'b00, 2'b00, 0, 0, 0, cause);
  endfunction

  task automatic chk(string nm, int idx, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d] got=%0h want=%0h", nm, idx, act, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic seen_ir;
    vec_t v;

    // reset cycle with ready high: strobes and mem_req stay low
    add(1, ADD, 0, 1, F, S0, 0, 0, 0, 0, 0, 2'b00);
    fd(ADD, 0); ex(ADD, 0, S0, 0, 0, 0, 6'b000000, 0);
    add(0, ADD, 0, 1, W, SWB, 2'b00, 2'b00, 0, 1, 0, 0);
    fd(SUB, 0); ex(SUB, 0, S0, 0, 0, 0, 6'b000001, 0);
    add(0, SUB, 0, 1, W, SWB, 2'b00, 2'b00, 0, 1, 0, 0);
    fd(LW, 0); ex(LW, 0, S0, 0, 0, 0, 6'b010000, 3'd0);
    for (int i = 0; i < 3; i++) add(0, LW, 0, 0, M, SF, 0, 0, 1, 0, 0, 0);
    add(0, LW, 0, 1, M, SML, 0, 0, 1, 0, 0, 0);
    add(0, LW, 0, 1, W, SWB, 2'b00, 2'b01, 0, 1, 0, 0);
    fd(SW, 0); ex(SW, 0, S0, 0, 0, 0, 6'b010000, 3'd1);
    add(0, SW, 0, 1, M, SMS, 2'b00, 0, 1, 1, 0, 0);
    fd(BEQ, 0); ex(BEQ, 1, SPC, 2'b01, 1, 0, 6'b110000, 3'd2);
    fd(BEQ, 0); ex(BEQ, 0, SPC, 2'b00, 1, 0, 6'b110000, 3'd2);
    fd(JAL, 0); ex(JAL, 0, S0, 0, 0, 0, 6'b110000, 3'd4);
    add(0, JAL, 0, 1, W, SWB, 2'b01, 2'b10, 0, 1, 0, 0);
    fd(LUI, 0); ex(LUI, 0, S0, 0, 0, 0, 6'b011010, 3'd3);
    add(0, LUI, 0, 1, W, SWB, 2'b00, 2'b00, 0, 1, 0, 0);
    // illegal opcode traps
    fd(ILL, 0);
    add(0, ILL, 0, 1, X, SPC, 2'b10, 0, 0, 0, 1, 2'b01);
    // load stalls in MEM until timeout
    fd(LW, 1); ex(LW, 0, S0, 0, 0, 1, 6'b010000, 3'd0);
    for (int i = 0; i < 4; i++) add(0, LW, 0, 0, M, SF, 0, 0, 1, 0, 0, 1);
    add(0, LW, 0, 0, X, SPC, 2'b10, 0, 0, 0, 1, 2'b10);
    // reset during a store wait
    fd(SW, 2); ex(SW, 0, S0, 0, 0, 2, 6'b010000, 3'd1);
    add(0, SW, 0, 0, M, SMW, 0, 0, 1, 0, 0, 2);
    add(1, SW, 0, 0, M, S0, 0, 0, 0, 0, 0, 2);
    for (int i = 0; i < 3; i++) add(0, SW, 0, 0, F, SF, 0, 0, 0, 0, 0, 0);
    add(0, SW, 0, 1, F, SFI, 0, 0, 0, 0, 0, 0);
    add(0, SW, 0, 1, D, S0, 0, 0, 0, 0, 0, 0);
    ex(SW, 0, S0, 0, 0, 0, 6'b010000, 3'd1);
    add(0, SW, 0, 1, M, SMS, 2'b00, 0, 1, 1, 0, 0);

    reset = 1'b1; instr = ADD; br_taken = 1'b0; mem_ready = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    for (int i = 0; i < tbl.size(); i++) begin
      v = tbl[i];
      reset = v.rst; instr = v.ins; br_taken = v.br; mem_ready = v.rdy;
      #2;
      chk("state", i, 32'(state_dbg), 32'(v.st));
      chk("strobes", i, 32'({mem_req, mem_we, ir_we, mdr_we, pc_we, ru_wr}), 32'(v.strb));
      chk("retired", i, 32'(instr_retired), 32'(v.ret));
      chk("fault", i, 32'(fault), 32'(v.flt));
      chk("cause", i, 32'(fault_cause), 32'(v.cause));
      chk("dm_ctrl", i, 32'(dm_ctrl), 32'(v.ins[14:12]));
      if (v.strb[1]) chk("pc_src", i, 32'(pc_src), 32'(v.pcs));
      if (v.strb[0]) chk("ru_data_src", i, 32'(ru_data_src), 32'(v.rus));
      if (v.strb[5]) chk("mem_addr_src", i, 32'(mem_addr_src), 32'(v.addr));
      if (v.chk) begin
        chk("alu_ctl", i, 32'({alu_a_src, alu_b_src, alu_op}), 32'(v.alu));
        if (v.alu[4]) chk("imm_src", i, 32'(imm_src), 32'(v.imm));
      end
      @(posedge CLK);
      #1;
    end

    // fetch stall: four wait cycles then FAULT with cause 10, never ir_we
    reset = 1'b0; instr = ADD; mem_ready = 1'b0;
    n = 0; seen_ir = 1'b0;
    while (state_dbg != X && n < 10) begin
      #2;
      if (ir_we) seen_ir = 1'b1;
      @(posedge CLK);
      #1;
      n++;
    end
    #2;
    chk("to_cycles", 0, 32'(n), 32'd4);
    chk("to_ir_we", 0, 32'(seen_ir), 32'd0);
    chk("to_fault", 0, 32'(fault), 32'd1);
    chk("to_cause", 0, 32'(fault_cause), 32'd2);
    chk("to_trap_pc", 0, 32'({pc_we, pc_src}), 32'b110);
    @(posedge CLK);
    #3;
    chk("to_refetch", 0, 32'(state_dbg), 32'(F));
    chk("to_fault_pulse", 0, 32'(fault), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
